// File: rtl/max_scan_if.sv
// Bundle between a host and the max-scan sequencer: buffer write port,
// scan request, and result/status signals.
interface max_scan_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [IDX_W:0]   count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic [1:0]       state_dbg;

  // Handshake: start is a request taken only while idle (no ready signal, no
  // queuing); busy covers the scan; done is a one-cycle valid for max_val/max_idx.
  modport master (
    output wr_en, wr_idx, wr_data, start, count,
    input  busy, done, max_val, max_idx, state_dbg
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, start, count,
    output busy, done, max_val, max_idx, state_dbg
  );
endinterface

// File: rtl/max_scan_sequencer.sv
// Finds the largest entry (and its index) of a small buffer using a single
// compare stage stepped over the entries by a sequencer.
module max_scan_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input logic       clk,
  input logic       rst,
  max_scan_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W + 1)'(1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  logic [WIDTH-1:0] cand;

  assign cand = buf_q[ptr_q[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    done_d    = 1'b0;
    buf_d     = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_en) buf_d[bus.wr_idx] = bus.wr_data;
        if (bus.start) begin
          cnt_d   = (bus.count == '0 || bus.count > DEPTH_C) ? DEPTH_C : bus.count;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        max_val_d = buf_q[0];
        max_idx_d = '0;
        ptr_d     = ONE_C;
        state_d   = (cnt_q == ONE_C) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        // Strictly greater replaces the incumbent, so ties keep the lower index.
        if (cand > max_val_q) begin
          max_val_d = cand;
          max_idx_d = ptr_q[IDX_W-1:0];
        end
        ptr_d = ptr_q + ONE_C;
        if (ptr_q == cnt_q - ONE_C) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_INIT) || (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.max_val   = max_val_q;
  assign bus.max_idx   = max_idx_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_max_scan_sequencer.sv
// Bench for max_scan_sequencer: a host model drives writes and scans, and a
// done-triggered monitor compares results, latency and busy length.
module tb_max_scan_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   busy_cyc;
  int   done_cnt;

  logic [WIDTH-1:0]       mdl_buf [DEPTH];
  logic [IDX_W+WIDTH-1:0] exp_q[$];
  int                     exp_cyc_q[$];
  int                     exp_busy_q[$];

  max_scan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  max_scan_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [IDX_W:0] c, input int e0);
    int n;
    logic [WIDTH-1:0] best;
    logic [IDX_W-1:0] bi;
    n = (c == 0 || c > DEPTH) ? DEPTH : int'(c);
    best = mdl_buf[0];
    bi = '0;
    for (int i = 1; i < n; i++) begin
      if (mdl_buf[i] > best) begin
        best = mdl_buf[i];
        bi = IDX_W'(i);
      end
    end
    exp_q.push_back({bi, best});
    exp_cyc_q.push_back(e0 + n + 1);
    exp_busy_q.push_back(n);
  endfunction

  // driver tasks
  task automatic write_entry(input int idx, input logic [WIDTH-1:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_idx = IDX_W'(idx);
    bus.wr_data = data;
    mdl_buf[idx] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic start_scan(input logic [IDX_W:0] c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = c;
    busy_cyc = 0;
    push_exp(c, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int base;
    int t;
    base = done_cnt;
    t = 0;
    while (done_cnt == base && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == base) check("done_timeout", done_cnt - base, 1);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (bus.busy) busy_cyc++;
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", exp_q.size(), 1);
      end else begin
        logic [IDX_W+WIDTH-1:0] e;
        int ec;
        int eb;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        eb = exp_busy_q.pop_front();
        check("max_val", bus.max_val, e[WIDTH-1:0]);
        check("max_idx", bus.max_idx, e[IDX_W+WIDTH-1:WIDTH]);
        check("done_cycle", cyc, ec);
        check("busy_cycles", busy_cyc, eb);
      end
    end
  end

  initial begin
    int base;
    logic [WIDTH-1:0] t1 [DEPTH];
    n_vec = 0;
    n_err = 0;
    busy_cyc = 0;
    done_cnt = 0;
    bus.wr_en = 1'b0;
    bus.wr_idx = '0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    bus.count = '0;
    for (int i = 0; i < DEPTH; i++) mdl_buf[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_max_val", bus.max_val, 0);
    check("rst_max_idx", bus.max_idx, 0);
    check("rst_state", bus.state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;

    // cleared buffer scans to zero
    start_scan(4'd8);
    wait_done(40);

    // ties keep the lowest index
    t1 = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd1, 16'd0, 16'd7, 16'd2};
    for (int i = 0; i < DEPTH; i++) write_entry(i, t1[i]);
    start_scan(4'd8);
    wait_done(40);

    // single-entry scan
    write_entry(0, 16'hFFFF);
    start_scan(4'd1);
    wait_done(40);

    // count 0 saturates, compare is unsigned
    for (int i = 0; i < DEPTH - 1; i++) write_entry(i, 16'h7FFF);
    write_entry(7, 16'h8000);
    start_scan(4'd0);
    wait_done(40);

    // write and restart while busy are both ignored
    for (int i = 0; i < DEPTH; i++) write_entry(i, t1[i]);
    start_scan(4'd8);
    repeat (2) @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_idx = 3'd2;
    bus.wr_data = 16'hFFFF;
    bus.start = 1'b1;
    bus.count = 4'd1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    base = done_cnt;
    wait_done(40);
    repeat (12) @(negedge clk);
    check("one_done_pulse", done_cnt - base, 1);
    start_scan(4'd3);
    wait_done(40);

    // same-edge write and start
    write_entry(1, 16'h0001);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_idx = 3'd0;
    bus.wr_data = 16'h1234;
    mdl_buf[0] = 16'h1234;
    bus.start = 1'b1;
    bus.count = 4'd2;
    busy_cyc = 0;
    push_exp(4'd2, cyc + 1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    wait_done(40);

    // reset mid-scan aborts
    for (int i = 0; i < DEPTH; i++) write_entry(i, t1[i]);
    start_scan(4'd8);
    repeat (4) @(posedge clk);
    #2;
    base = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_max_val", bus.max_val, 0);
    check("abort_max_idx", bus.max_idx, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_busy_q.delete();
    for (int i = 0; i < DEPTH; i++) mdl_buf[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    start_scan(4'd5);
    wait_done(40);
    write_entry(4, 16'h00A5);
    start_scan(4'd6);
    wait_done(40);

    // random buffers and counts (counts above DEPTH saturate)
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DEPTH; i++) write_entry(i, WIDTH'($urandom_range(0, 20)));
      start_scan((IDX_W + 1)'($urandom_range(0, 15)));
      wait_done(40);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
